// File: rtl/fir_seq_ctrl_pkg.sv
// fir_pkg: shared definitions for the FIR sequencer.
//   - FSM state encoding (kept as plain 2-bit constants so older code that
//     decodes the raw state bits keeps working)
//   - default sample-period / tap-count / address-width values
//   - cfgLegal(): parameter legality check used at elaboration
package fir_pkg;

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;
  localparam logic [1:0] ST_UPD   = 2'd3;

  localparam int CLK_DIV_DEF  = 20;   // 12 MHz / 20 = 600 kHz
  localparam int NUM_TAPS_DEF = 10;
  localparam int ADDR_W_DEF   = 4;

  // A pass (CLEAR + NUM_TAPS MAC cycles) must end before the next strobe,
  // and every tap index must fit in the address bus.
  function automatic bit cfgLegal(int clkDiv, int numTaps, int addrW);
    return (clkDiv >= 4) && (clkDiv <= 256) &&
           (numTaps >= 1) && (numTaps <= clkDiv - 3) &&
           ((1 << addrW) >= numTaps);
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: control bundle between the FIR sequencer and its
// neighbours (host coefficient port, delay line, MAC lane, sum stage).
//   iEnable          run enable from the system
//   iCoefReq/oCoefAck host coefficient-bank request / grant
//   oEnSample_600k   one-cycle sample strobe
//   oShiftEn/oAccClr delay-line shift and accumulator clear
//   oMacEn/oCoefAddr MAC enable and tap index
//   oEnDelay         MAC result valid
//   oOverrun         sticky missed-sample flag
// master = sequencer, slave = the rest of the datapath / host.
interface fir_seq_ctrl_if
  import fir_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              iEnable;
  logic              iCoefReq;
  logic              oCoefAck;
  logic              oEnSample_600k;
  logic              oShiftEn;
  logic              oAccClr;
  logic              oMacEn;
  logic [ADDR_W-1:0] oCoefAddr;
  logic              oEnDelay;
  logic              oOverrun;

  modport master (
    input  iEnable, iCoefReq,
    output oCoefAck, oEnSample_600k, oShiftEn, oAccClr, oMacEn,
           oCoefAddr, oEnDelay, oOverrun
  );

  modport slave (
    output iEnable, iCoefReq,
    input  oCoefAck, oEnSample_600k, oShiftEn, oAccClr, oMacEn,
           oCoefAddr, oEnDelay, oOverrun
  );
endinterface

// File: rtl/fir_seq_ctrl_strobe_gen.sv
// fir_strobe_gen: modulo-CLK_DIV sample counter with registered strobe.
//   iClk_12M  clock
//   iRst      async active-high reset
//   iEn       count enable
//   iClr      synchronous clear (counter and strobe to 0)
//   oStrobe   high for the one cycle in which the count sits at CLK_DIV-1
module fir_strobe_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic iClk_12M,
  input  logic iRst,
  input  logic iEn,
  input  logic iClr,
  output logic oStrobe
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] rCnt;
  logic             rStrobe;

  // The strobe is registered one count early so it lines up with rCnt==LAST
  // without a combinational decode on the output.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      rCnt    <= '0;
      rStrobe <= 1'b0;
    end else if (iClr) begin
      rCnt    <= '0;
      rStrobe <= 1'b0;
    end else if (iEn) begin
      rCnt    <= (rCnt == LAST) ? '0 : rCnt + 1'b1;
      rStrobe <= (rCnt == PRE);
    end else begin
      rStrobe <= 1'b0;
    end
  end

  assign oStrobe = rStrobe;
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: FIR datapath sequencer (12 MHz domain).
//   iClk_12M  clock
//   iRst      async active-high reset
//   bus       fir_seq_ctrl_if.master: enable, coefficient handshake and all
//             datapath controls (see the interface header)
// Per sample: strobe -> CLEAR (shift + acc clear) -> NUM_TAPS MAC cycles ->
// WAIT. Host coefficient updates (UPD) are only granted from WAIT, so the
// coefficient bank never changes mid-pass. Every output is a flop.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic           iClk_12M,
  input  logic           iRst,
  fir_seq_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  if (!cfgLegal(CLK_DIV, NUM_TAPS, ADDR_W)) begin : gCfgErr
    $error("fir_seq_ctrl: illegal CLK_DIV/NUM_TAPS/ADDR_W combination");
  end

  logic              strobe;
  logic [1:0]        rState, nState;
  logic [ADDR_W-1:0] rAddr;
  logic              rShift, rMacEn, rAck, rValid, rOvr;

  fir_strobe_gen #(.CLK_DIV(CLK_DIV)) uStrobe (
    .iClk_12M (iClk_12M),
    .iRst     (iRst),
    .iEn      (bus.iEnable),
    .iClr     (!bus.iEnable),
    .oStrobe  (strobe)
  );

  // Dropping iEnable aborts a pass immediately; an update in progress is
  // left to the host to finish.
  always_comb begin
    nState = rState;
    case (rState)
      ST_WAIT:  if (strobe && bus.iEnable) nState = ST_CLEAR;
                else if (bus.iCoefReq)     nState = ST_UPD;
      ST_CLEAR: nState = bus.iEnable ? ST_MAC : ST_WAIT;
      ST_MAC:   if (!bus.iEnable || rAddr == LAST_TAP) nState = ST_WAIT;
      ST_UPD:   if (!bus.iCoefReq) nState = ST_WAIT;
      default:  nState = ST_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      rState <= ST_WAIT;
      rAddr  <= '0;
      rShift <= 1'b0;
      rMacEn <= 1'b0;
      rAck   <= 1'b0;
      rValid <= 1'b0;
      rOvr   <= 1'b0;
    end else begin
      rState <= nState;
      rShift <= (nState == ST_CLEAR);
      rMacEn <= (nState == ST_MAC);
      rAck   <= (nState == ST_UPD);
      rAddr  <= (rState == ST_MAC && nState == ST_MAC) ? rAddr + 1'b1 : '0;
      // A strobe outside WAIT is a sample the datapath never processed.
      rOvr   <= rOvr | (strobe && rState != ST_WAIT);
      if (!bus.iEnable)
        rValid <= 1'b0;
      else if (rState == ST_MAC && nState == ST_WAIT)
        rValid <= 1'b1;
      else if (rState == ST_UPD && nState == ST_WAIT)
        rValid <= 1'b0;     // new coefficients: wait for a fresh full pass
    end
  end

  assign bus.oEnSample_600k = strobe;
  assign bus.oShiftEn       = rShift;
  assign bus.oAccClr        = rShift;
  assign bus.oMacEn         = rMacEn;
  assign bus.oCoefAddr      = rAddr;
  assign bus.oCoefAck       = rAck;
  assign bus.oEnDelay       = rValid;
  assign bus.oOverrun       = rOvr;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: self-checking bench for fir_seq_ctrl (default parameters).
// A behavioural model tracks the sample counter and the position inside the
// current pass as plain integers and is compared with the DUT every cycle;
// a checkpoint table covers the first two sample periods and hand-written
// sequences cover the coefficient-request, enable-drop and reset corners.
module tb_fir_seq_ctrl;
  localparam int CLK_DIV  = 20;
  localparam int NUM_TAPS = 10;
  localparam int ADDR_W   = 4;

  typedef struct packed {
    logic              strobe, shift, accClr, macEn;
    logic [ADDR_W-1:0] addr;
    logic              enDelay, ack, ovr;
  } outs_t;

  typedef struct {
    int    cyc;
    bit    en, req;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  fir_seq_ctrl #(.CLK_DIV(CLK_DIV), .NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W)) dut (
    .iClk_12M (clk),
    .iRst     (rst),
    .bus      (bus)
  );

  int nRun  = 0;
  int nFail = 0;
  bit chk   = 1'b0;

  // ---------------- reference model ----------------
  // mPos: -1 idle, 0 clear cycle, 1..NUM_TAPS = tap mPos-1 being accumulated
  int mCnt = 0, mPos = -1;
  bit mStrobe = 0, mUpd = 0, mValid = 0, mOvr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCnt = 0; mPos = -1; mStrobe = 0; mUpd = 0; mValid = 0; mOvr = 0;
    end else begin
      bit en, req, idle;
      en   = bus.iEnable;
      req  = bus.iCoefReq;
      idle = (mPos < 0) && !mUpd;
      if (mStrobe && !idle) mOvr = 1;
      if (mUpd) begin
        if (!req) begin mUpd = 0; mValid = 0; end
      end else if (mPos >= 0) begin
        if (!en) mPos = -1;
        else if (mPos == NUM_TAPS) begin mPos = -1; mValid = 1; end
        else mPos++;
      end else if (mStrobe && en) mPos = 0;
      else if (req) mUpd = 1;
      if (!en) mValid = 0;
      mStrobe = en && (mCnt == CLK_DIV - 2);
      mCnt    = en ? (mCnt + 1) % CLK_DIV : 0;
    end
  end

  function automatic outs_t modelOuts();
    outs_t o;
    o.strobe  = mStrobe;
    o.shift   = (mPos == 0);
    o.accClr  = (mPos == 0);
    o.macEn   = (mPos >= 1);
    o.addr    = (mPos >= 1) ? ADDR_W'(mPos - 1) : '0;
    o.enDelay = mValid;
    o.ack     = mUpd;
    o.ovr     = mOvr;
    return o;
  endfunction

  function automatic outs_t dutOuts();
    outs_t o;
    o.strobe  = bus.oEnSample_600k;
    o.shift   = bus.oShiftEn;
    o.accClr  = bus.oAccClr;
    o.macEn   = bus.oMacEn;
    o.addr    = bus.oCoefAddr;
    o.enDelay = bus.oEnDelay;
    o.ack     = bus.oCoefAck;
    o.ovr     = bus.oOverrun;
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      outs_t a, e;
      a = dutOuts();
      e = modelOuts();
      nRun++;
      if (a !== e) begin
        nFail++;
        $display("FAIL model t=%0t act=%h exp=%h", $time, a, e);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(string name, int act, int exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOuts(string name, outs_t act, outs_t exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Advance to the next negedge at which the sample counter equals k.
  task automatic waitCnt(int k);
    int n = 0;
    do begin @(negedge clk); n++; end while (mCnt != k && n < 200);
    if (mCnt != k) begin
      nRun++; nFail++;
      $display("FAIL waitCnt timeout act=%0d exp=%0d", mCnt, k);
    end
  endtask

  task automatic cyclesToStrobe(string name, int exp);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.oEnSample_600k && n < 100);
    check(name, n, exp);
  endtask

  function automatic vec_t row(int c, bit s, bit sh, bit mac, int a, bit d);
    vec_t v;
    v.cyc = c; v.en = 1'b1; v.req = 1'b0;
    v.exp = '0;
    v.exp.strobe = s; v.exp.shift = sh; v.exp.accClr = sh;
    v.exp.macEn = mac; v.exp.addr = ADDR_W'(a); v.exp.enDelay = d;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    vec_t vt[$];
    int   cyc, macCnt;
    bit   en, req;

    vt.push_back(row( 0, 0, 0, 0, 0, 0));
    vt.push_back(row(18, 0, 0, 0, 0, 0));
    vt.push_back(row(19, 1, 0, 0, 0, 0));
    vt.push_back(row(20, 0, 1, 0, 0, 0));
    vt.push_back(row(21, 0, 0, 1, 0, 0));
    vt.push_back(row(25, 0, 0, 1, 4, 0));
    vt.push_back(row(30, 0, 0, 1, 9, 0));
    vt.push_back(row(31, 0, 0, 0, 0, 1));
    vt.push_back(row(38, 0, 0, 0, 0, 1));
    vt.push_back(row(39, 1, 0, 0, 0, 1));
    vt.push_back(row(40, 0, 1, 0, 0, 1));
    vt.push_back(row(44, 0, 0, 1, 3, 1));
    vt.push_back(row(50, 0, 0, 1, 9, 1));
    vt.push_back(row(51, 0, 0, 0, 0, 1));

    bus.iEnable  = 1'b0;
    bus.iCoefReq = 1'b0;
    repeat (3) @(negedge clk);
    checkOuts("reset_outs", dutOuts(), '0);
    rst = 1'b0;
    bus.iEnable = 1'b1;
    chk = 1'b1;

    // Checkpoint table: cycle 0 is the cycle enable first rises after reset.
    cyc = 0;
    foreach (vt[i]) begin
      while (cyc < vt[i].cyc) begin @(negedge clk); cyc++; end
      bus.iEnable  = vt[i].en;
      bus.iCoefReq = vt[i].req;
      checkOuts($sformatf("table_c%0d", vt[i].cyc), dutOuts(), vt[i].exp);
    end

    // Coefficient update entirely inside WAIT.
    waitCnt(14); bus.iCoefReq = 1'b1;
    check("updA_ack_not_yet", bus.oCoefAck, 0);
    waitCnt(15); check("updA_ack", bus.oCoefAck, 1);
    waitCnt(17); check("updA_ack_hold", bus.oCoefAck, 1);
    bus.iCoefReq = 1'b0;
    waitCnt(18); check("updA_ack_drop", bus.oCoefAck, 0);
    check("updA_dly_clr", bus.oEnDelay, 0);
    waitCnt(11); check("updA_dly_back", bus.oEnDelay, 1);
    check("updA_no_ovr", bus.oOverrun, 0);

    // Update held across a strobe: missed sample.
    waitCnt(2); bus.iCoefReq = 1'b1;
    waitCnt(0); check("updB_ovr", bus.oOverrun, 1);
    check("updB_ack_kept", bus.oCoefAck, 1);
    macCnt = 0;
    repeat (10) begin @(negedge clk); macCnt += int'(bus.oMacEn); end
    check("updB_no_mac", macCnt, 0);
    waitCnt(12); bus.iCoefReq = 1'b0;
    waitCnt(13); check("updB_ovr_sticky", bus.oOverrun, 1);
    waitCnt(1);  check("updB_mac_resume", bus.oMacEn, 1);
    waitCnt(11); check("updB_dly", bus.oEnDelay, 1);

    // Request in the strobe cycle: the pass runs first.
    waitCnt(19); check("updC_strobe", bus.oEnSample_600k, 1);
    bus.iCoefReq = 1'b1;
    waitCnt(0);  check("updC_clear", bus.oShiftEn, 1);
    check("updC_ack0", bus.oCoefAck, 0);
    waitCnt(10); check("updC_last_tap", bus.oCoefAddr, 9);
    check("updC_ack_in_mac", bus.oCoefAck, 0);
    waitCnt(11); check("updC_ack_wait", bus.oCoefAck, 0);
    waitCnt(12); check("updC_ack", bus.oCoefAck, 1);
    bus.iCoefReq = 1'b0;
    waitCnt(13); check("updC_dly_clr", bus.oEnDelay, 0);

    // Enable dropped mid-pass.
    waitCnt(11); check("enD_dly_pre", bus.oEnDelay, 1);
    waitCnt(5);  check("enD_addr4", bus.oCoefAddr, 4);
    bus.iEnable = 1'b0;
    @(negedge clk);
    check("enD_mac_off", bus.oMacEn, 0);
    check("enD_dly_off", bus.oEnDelay, 0);
    check("enD_addr0", bus.oCoefAddr, 0);
    macCnt = 0;
    repeat (30) begin @(negedge clk); macCnt += int'(bus.oEnSample_600k); end
    check("enD_no_strobe", macCnt, 0);
    bus.iEnable = 1'b1;
    cyclesToStrobe("enD_first_strobe", 19);

    // Asynchronous reset between edges while accumulating.
    waitCnt(5);
    check("rst_mid_mac", bus.oMacEn, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1 checkOuts("rst_async_outs", dutOuts(), '0);
    #4 rst = 1'b0;
    cyclesToStrobe("rst_first_strobe", 19);

    // Randomised run against the model.
    en = 1'b1; req = 1'b0;
    repeat (2500) begin
      @(negedge clk);
      if (en) en = ($urandom_range(0, 199) != 0);
      else    en = ($urandom_range(0, 4) == 0);
      if (req) req = ($urandom_range(0, 7) != 0);
      else     req = ($urandom_range(0, 39) == 0);
      bus.iEnable  = en;
      bus.iCoefReq = req;
    end
    @(negedge clk);
    chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule
